ifmap_window_gen: RTL and testbench
===================================

# ifmap_window_gen

Streaming window generator that feeds the convolution engine. It accepts input feature-map pixels in raster order over a valid/ready handshake and buffers the last FILTER_SIZE rows. It emits each FILTER_SIZE×FILTER_SIZE window at the configured STRIDE, together with its output-map coordinates. It is the producer end of the window interface the conv datapath consumes, and sits between the ifmap source and the conv MAC array.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IFMAP_SIZE, 5, ifmap side length (square).
- FILTER_SIZE, 3, window side length.
- STRIDE, 1, window step in both dimensions.
- OFMAP_SIZE, (IFMAP_SIZE-FILTER_SIZE)/STRIDE+1, derived; not overridden.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  pixel present.
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  pixel value.
- out_valid  out  1  window present.
- out_ready  in  1  window consumed when out_valid && out_ready.
- out_window  out  FILTER_SIZE*FILTER_SIZE*DATA_WIDTH  element (i,j) at bits [(i*FILTER_SIZE+j)*DATA_WIDTH +: DATA_WIDTH]. i is the row (0 = top), j is the column (0 = left).
- out_row, out_col  out  max(1,$clog2(OFMAP_SIZE))  ofmap coordinates of the window.
- out_last  out  1  window is the final window of the frame.
- frame_done  out  1  one-cycle pulse when the last window handshakes.

## Operation
- Pixel counters: in_r and in_c, range 0..IFMAP_SIZE-1.
  - Advance on each accepted pixel.
  - in_c wraps to 0 and in_r increments.
  - After pixel (IFMAP_SIZE-1, IFMAP_SIZE-1) both counters return to 0, and the next pixel starts a new frame.
- Row storage: FILTER_SIZE row buffers of IFMAP_SIZE entries each.
  - Accepted pixel is written to buffer in_r mod FILTER_SIZE, entry in_c.
- Window trigger: an accepted pixel at (r,c) completes a window iff all of the following hold:
  - r ≥ FILTER_SIZE-1
  - c ≥ FILTER_SIZE-1
  - (r-FILTER_SIZE+1) mod STRIDE == 0
  - (c-FILTER_SIZE+1) mod STRIDE == 0
- Window contents: rows r-FILTER_SIZE+1..r, columns c-FILTER_SIZE+1..c, assembled from the buffers plus the bypassed incoming pixel.
  - Registered into out_window.
  - out_row = (r-FILTER_SIZE+1)/STRIDE, out_col = (c-FILTER_SIZE+1)/STRIDE.
- Pixels in columns or rows skipped by the stride are stored but produce no window.
- in_ready = !out_valid || out_ready (combinational; one-deep output register).
- FSM:
  - IDLE: no pixel of the current frame accepted yet. First accepted pixel → ACTIVE.
  - ACTIVE: streaming. The accepted pixel that completes the window with out_row = out_col = OFMAP_SIZE-1 → LAST.
  - LAST: out_valid=1 and out_last=1 with the final window; in_ready=0 regardless of out_ready. The out handshake → IDLE with frame_done=1 for that cycle.
- Reset values: out_valid 0, out_window 0, out_row 0, out_col 0, out_last 0, frame_done 0, counters 0, state IDLE. Row buffer contents are not reset.
- Reset mid-frame: the partial frame is discarded, and the next accepted pixel is treated as (0,0).

## Timing
- Latency: window valid the cycle after the completing pixel is accepted.
- Throughput: one pixel per cycle while out_ready=1. A window and a new pixel may handshake in the same cycle; the output register is reloaded or cleared accordingly.
- out_window, out_row, out_col and out_last are stable while out_valid && !out_ready.
- out_valid drops the cycle after the handshake unless a new window is loaded in that same cycle.

## Structure
- Shared CNN params package:
  - holds FILTER_SIZE, IFMAP_SIZE, STRIDE and the derived OFMAP_SIZE;
  - gains WIN_ELEMS = FILTER_SIZE*FILTER_SIZE;
  - gains a window-state enum typedef (IDLE, ACTIVE, LAST).
- One sub-module, ifmap_row_buffer: a FILTER_SIZE×IFMAP_SIZE register array with one write port and parallel column reads.

## Test plan
- Defaults (5/3/1), pixel(r,c)=r*5+c+1, in_valid and out_ready held at 1:
  - first window 1,2,3,6,7,8,11,12,13 at (0,0), one cycle after pixel 13 is accepted;
  - 9 windows in total;
  - last window 13,14,15,18,19,20,23,24,25 with out_last=1 and a frame_done pulse.
- STRIDE=2, same stimulus: exactly 4 windows, at (0,0),(0,1),(1,0),(1,1). Window (1,1) = 13,14,15,18,19,20,23,24,25.
- Backpressure: out_ready=0 for 5 cycles after the first window.
  - in_ready=0 for those cycles; window held unchanged.
  - Stream resumes with no lost or duplicated pixel.
- Back-to-back frames with pixel(r,c)+100 in the second frame:
  - in_ready=0 while in LAST;
  - the second frame's first window is 101,102,103,106,107,108,111,112,113.
- Reset: assert rst_n=0 after 8 pixels.
  - Outputs return to reset values asynchronously.
  - A fresh full frame then yields 9 correct windows.
- Randomized in_valid/out_ready gaps over 3 frames: window sequence is identical to the ungapped reference run.

Source files
------------

// File: rtl/ifmap_window_gen_pkg.sv
// Shared CNN parameters for the ifmap window generator.
// Holds the default geometry and the window FSM state type.
package ifmap_window_gen_pkg;
  localparam int FILTER_SIZE = 3;
  localparam int IFMAP_SIZE  = 5;
  localparam int STRIDE      = 1;
  localparam int OFMAP_SIZE  = (IFMAP_SIZE - FILTER_SIZE) / STRIDE + 1;
  localparam int WIN_ELEMS   = FILTER_SIZE * FILTER_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    LAST
  } win_state_e;
endpackage

// File: rtl/ifmap_row_buffer.sv
// Rows x cols pixel store: one write port,
// parallel read of RD_COLS adjacent columns from every row.
module ifmap_row_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 3,
  parameter int COLS       = 5,
  parameter int RD_COLS    = 3,
  parameter int ROW_W      = 2,
  parameter int COL_W      = 3
) (
  input  logic                               clk,
  input  logic                               we,
  input  logic [ROW_W-1:0]                   wr_row,
  input  logic [COL_W-1:0]                   wr_col,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic [COL_W-1:0]                   rd_col,
  output logic [ROWS*RD_COLS*DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [ROWS][COLS];

  always_ff @(posedge clk) begin
    if (we) mem[wr_row][wr_col] <= wr_data;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar j = 0; j < RD_COLS; j++) begin : g_col
      logic [COL_W:0] idx;
      assign idx = {1'b0, rd_col} + (COL_W+1)'(j);
      assign rd_data[(r*RD_COLS+j)*DATA_WIDTH +: DATA_WIDTH] =
        (idx < (COL_W+1)'(COLS)) ? mem[r][idx[COL_W-1:0]] : '0;
    end
  end
endmodule

// File: rtl/ifmap_window_gen.sv
// Streaming FILTER_SIZE x FILTER_SIZE window generator over a
// raster-order pixel stream, with a one-deep output register.
module ifmap_window_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int IFMAP_SIZE  = ifmap_window_gen_pkg::IFMAP_SIZE,
  parameter int FILTER_SIZE = ifmap_window_gen_pkg::FILTER_SIZE,
  parameter int STRIDE      = ifmap_window_gen_pkg::STRIDE,
  localparam int OFMAP_SIZE = (IFMAP_SIZE - FILTER_SIZE) / STRIDE + 1,
  localparam int CRD_W = (OFMAP_SIZE > 1) ? $clog2(OFMAP_SIZE) : 1,
  localparam int WIN_W = FILTER_SIZE * FILTER_SIZE * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIN_W-1:0]      out_window,
  output logic [CRD_W-1:0]      out_row,
  output logic [CRD_W-1:0]      out_col,
  output logic                  out_last,
  output logic                  frame_done
);
  import ifmap_window_gen_pkg::*;

  localparam int PIX_W = (IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE) : 1;
  localparam int ROW_W = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;

  win_state_e state, state_n;
  logic [PIX_W-1:0] in_r, in_c;
  logic [ROW_W-1:0] wr_row;
  logic accept, trigger, final_win;
  logic [CRD_W-1:0] win_row, win_col;
  logic [WIN_W-1:0] rd_data, win;
  int r_off, c_off, b;

  assign in_ready   = (state != LAST) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign frame_done = (state == LAST) && out_ready;

  ifmap_row_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .ROWS      (FILTER_SIZE),
    .COLS      (IFMAP_SIZE),
    .RD_COLS   (FILTER_SIZE),
    .ROW_W     (ROW_W),
    .COL_W     (PIX_W)
  ) u_rows (
    .clk    (clk),
    .we     (accept),
    .wr_row (wr_row),
    .wr_col (in_c),
    .wr_data(in_data),
    .rd_col (in_c - PIX_W'(FILTER_SIZE - 1)),
    .rd_data(rd_data)
  );

  always_comb begin
    r_off     = int'(in_r) - (FILTER_SIZE - 1);
    c_off     = int'(in_c) - (FILTER_SIZE - 1);
    trigger   = (r_off >= 0) && (c_off >= 0) &&
                (r_off % STRIDE == 0) && (c_off % STRIDE == 0);
    win_row   = CRD_W'(r_off / STRIDE);
    win_col   = CRD_W'(c_off / STRIDE);
    final_win = trigger &&
                (r_off / STRIDE == OFMAP_SIZE - 1) &&
                (c_off / STRIDE == OFMAP_SIZE - 1);
  end

  // Oldest window row lives in the buffer after the one being written.
  always_comb begin
    win = '0;
    b   = 0;
    for (int i = 0; i < FILTER_SIZE; i++) begin
      for (int j = 0; j < FILTER_SIZE; j++) begin
        b = int'(wr_row) + 1 + i;
        if (b >= FILTER_SIZE) b = b - FILTER_SIZE;
        if (i == FILTER_SIZE - 1 && j == FILTER_SIZE - 1)
          win[(i*FILTER_SIZE+j)*DATA_WIDTH +: DATA_WIDTH] = in_data;
        else
          win[(i*FILTER_SIZE+j)*DATA_WIDTH +: DATA_WIDTH] =
            rd_data[(b*FILTER_SIZE+j)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_r   <= '0;
      in_c   <= '0;
      wr_row <= '0;
    end else if (accept) begin
      if (in_c == PIX_W'(IFMAP_SIZE - 1)) begin
        in_c <= '0;
        if (in_r == PIX_W'(IFMAP_SIZE - 1)) begin
          in_r   <= '0;
          wr_row <= '0;
        end else begin
          in_r   <= in_r + 1'b1;
          wr_row <= (wr_row == ROW_W'(FILTER_SIZE - 1)) ?
                    '0 : wr_row + 1'b1;
        end
      end else begin
        in_c <= in_c + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_window <= '0;
      out_row    <= '0;
      out_col    <= '0;
      out_last   <= 1'b0;
    end else if (accept && trigger) begin
      out_valid  <= 1'b1;
      out_window <= win;
      out_row    <= win_row;
      out_col    <= win_col;
      out_last   <= final_win;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (accept) state_n = final_win ? LAST : ACTIVE;
      ACTIVE: if (accept && final_win) state_n = LAST;
      LAST:   if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ifmap_window_gen.sv
// Self-checking bench for ifmap_window_gen: frame-level model,
// stride-2 instance, backpressure, reset and random gaps.
module tb_ifmap_window_gen;
  localparam int DW = 8;
  localparam int N  = 5;
  localparam int F  = 3;
  localparam int WW = F * F * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic [WW-1:0] out_window;
  logic [1:0]    out_row, out_col;
  logic          out_last, frame_done;

  logic          rst_n_b = 1'b0, in_valid_b = 1'b0, in_ready_b;
  logic          out_valid_b, out_ready_b = 1'b1;
  logic [DW-1:0] in_data_b = '0;
  logic [WW-1:0] out_window_b;
  logic [0:0]    out_row_b, out_col_b;
  logic          out_last_b, frame_done_b;

  ifmap_window_gen u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_window(out_window), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .frame_done(frame_done)
  );

  ifmap_window_gen #(.STRIDE(2)) u_dut_s2 (
    .clk(clk), .rst_n(rst_n_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_window(out_window_b), .out_row(out_row_b), .out_col(out_col_b),
    .out_last(out_last_b), .frame_done(frame_done_b)
  );

  typedef struct {
    logic [WW-1:0] win;
    int            row;
    int            col;
    int            last;
  } win_t;

  int   errors = 0;
  int   checks = 0;
  int   img [N][N];
  int   k = 0;
  win_t exp_q[$];
  win_t obs_q[$];
  win_t obs_b[$];
  win_t w;
  int   fd_count = 0, bp_seen = 0, last_bad = 0, last_cycles = 0;
  int   bp_cnt = 0, rr, cc;
  bit   bp_arm = 0, rnd = 0, ohs, ihs, showing, prev_hold = 0;
  logic [WW-1:0] prev_win;
  int   lit [9];

  task automatic check_i(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_w(string name, logic [WW-1:0] act, logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] pack9(input int a [9]);
    logic [WW-1:0] v = '0;
    for (int e = 0; e < 9; e++) v[e*DW +: DW] = DW'(a[e]);
    return v;
  endfunction

  function automatic logic [WW-1:0] model_win(int r0, int c0);
    logic [WW-1:0] v = '0;
    for (int i = 0; i < F; i++)
      for (int j = 0; j < F; j++)
        v[(i*F+j)*DW +: DW] = DW'(img[r0+i][c0+j]);
    return v;
  endfunction

  function automatic logic [WW-1:0] pix_win(int r0, int c0, int off);
    logic [WW-1:0] v = '0;
    for (int i = 0; i < F; i++)
      for (int j = 0; j < F; j++)
        v[(i*F+j)*DW +: DW] = DW'((r0+i)*N + (c0+j) + 1 + off);
    return v;
  endfunction

  // Model and per-cycle compare for the stride-1 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      k = 0;
      prev_hold = 0;
    end else begin
      ohs     = out_valid && out_ready;
      ihs     = in_valid && in_ready;
      showing = exp_q.size() > 0;
      check_i("in_ready", int'(in_ready),
              int'(!(showing && exp_q[0].last == 1) &&
                   (!showing || out_ready)));
      check_i("out_valid", int'(out_valid), int'(showing));
      if (out_valid && showing) begin
        check_w("window", out_window, exp_q[0].win);
        check_i("out_row", int'(out_row), exp_q[0].row);
        check_i("out_col", int'(out_col), exp_q[0].col);
        check_i("out_last", int'(out_last), exp_q[0].last);
      end
      if (prev_hold) begin
        check_i("hold_valid", int'(out_valid), 1);
        check_w("hold_window", out_window, prev_win);
      end
      check_i("frame_done", int'(frame_done),
              int'(ohs && showing && exp_q[0].last == 1));
      if (frame_done) fd_count++;
      if (out_valid && !out_ready && !in_ready) bp_seen++;
      if (out_valid && out_last) begin
        last_cycles++;
        if (in_ready) last_bad++;
      end
      prev_hold = out_valid && !out_ready;
      prev_win  = out_window;
      if (ohs) begin
        w.win  = out_window;
        w.row  = int'(out_row);
        w.col  = int'(out_col);
        w.last = int'(out_last);
        obs_q.push_back(w);
        if (showing) void'(exp_q.pop_front());
      end
      if (ihs) begin
        rr = k / N;
        cc = k % N;
        img[rr][cc] = int'(in_data);
        if (rr >= F-1 && cc >= F-1) begin
          w.win  = model_win(rr-F+1, cc-F+1);
          w.row  = rr-F+1;
          w.col  = cc-F+1;
          w.last = int'(rr == N-1 && cc == N-1);
          exp_q.push_back(w);
        end
        k = (k + 1) % (N*N);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n_b && out_valid_b && out_ready_b) begin
      w.win  = out_window_b;
      w.row  = int'(out_row_b);
      w.col  = int'(out_col_b);
      w.last = int'(out_last_b);
      obs_b.push_back(w);
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_cnt > 0) begin
      out_ready = 1'b0;
      bp_cnt--;
    end else if (bp_arm && out_valid) begin
      bp_arm    = 0;
      bp_cnt    = 4;
      out_ready = 1'b0;
    end else if (rnd) begin
      out_ready = 1'($urandom_range(0, 1));
    end else begin
      out_ready = 1'b1;
    end
  end

  task automatic send(int d, bit gaps, bit sel);
    int  n = 0;
    bit  acc;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    if (sel) begin in_valid_b = 1'b1; in_data_b = DW'(d); end
    else     begin in_valid   = 1'b1; in_data   = DW'(d); end
    forever begin
      @(negedge clk);
      acc = sel ? in_ready_b : in_ready;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        errors++; checks++;
        $display("FAIL send_timeout: pixel %0d not accepted", d);
        break;
      end
    end
    if (sel) in_valid_b = 1'b0;
    else     in_valid   = 1'b0;
  endtask

  task automatic frame(int off, bit gaps, bit sel);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        send(r*N + c + 1 + off, gaps, sel);
  endtask

  task automatic drain();
    int n = 0;
    while ((out_valid || exp_q.size() > 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      errors++; checks++;
      $display("FAIL drain_timeout: out_valid=%0d pending=%0d",
               out_valid, exp_q.size());
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(string tag);
    check_i({tag, "_valid"}, int'(out_valid), 0);
    check_w({tag, "_window"}, out_window, '0);
    check_i({tag, "_row"}, int'(out_row), 0);
    check_i({tag, "_col"}, int'(out_col), 0);
    check_i({tag, "_last"}, int'(out_last), 0);
    check_i({tag, "_fdone"}, int'(frame_done), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    check_i("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    rst_n_b = 1'b1;
    @(posedge clk); #1;

    // Ungapped default frame.
    obs_q.delete(); fd_count = 0;
    frame(0, 0, 0);
    drain();
    check_i("p1_count", obs_q.size(), 9);
    lit = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
    check_w("p1_first", obs_q[0].win, pack9(lit));
    check_i("p1_first_rc", obs_q[0].row * 10 + obs_q[0].col, 0);
    lit = '{13, 14, 15, 18, 19, 20, 23, 24, 25};
    check_w("p1_last", obs_q[8].win, pack9(lit));
    check_i("p1_last_flag", obs_q[8].last, 1);
    check_i("p1_fdone", fd_count, 1);

    // Stride 2 instance.
    obs_b.delete();
    frame(0, 0, 1);
    repeat (4) @(posedge clk); #1;
    check_i("s2_count", obs_b.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_i("s2_row", obs_b[i].row, i / 2);
      check_i("s2_col", obs_b[i].col, i % 2);
      check_w("s2_win", obs_b[i].win, pix_win(2*(i/2), 2*(i%2), 0));
    end
    lit = '{13, 14, 15, 18, 19, 20, 23, 24, 25};
    check_w("s2_win11", obs_b[3].win, pack9(lit));
    check_i("s2_last", obs_b[3].last, 1);

    // Backpressure after the first window.
    obs_q.delete(); bp_seen = 0; bp_arm = 1;
    frame(30, 0, 0);
    drain();
    check_i("bp_count", obs_q.size(), 9);
    check_i("bp_cycles", bp_seen, 5);

    // Back-to-back frames.
    obs_q.delete(); last_bad = 0; last_cycles = 0;
    frame(0, 0, 0);
    frame(100, 0, 0);
    drain();
    check_i("b2b_count", obs_q.size(), 18);
    lit = '{101, 102, 103, 106, 107, 108, 111, 112, 113};
    check_w("b2b_first2", obs_q[9].win, pack9(lit));
    check_i("b2b_last_cycles", last_cycles, 2);
    check_i("b2b_last_ready", last_bad, 0);

    // Reset after 8 pixels, then after 14 with a window held.
    for (int i = 0; i < 8; i++) send(i + 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst8");
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 14; i++) send(i + 1, 0, 0);
    check_i("pre_rst14_valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst14");
    @(posedge clk); #1 rst_n = 1'b1;
    obs_q.delete();
    frame(0, 0, 0);
    drain();
    check_i("rst_frame_count", obs_q.size(), 9);
    lit = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
    check_w("rst_frame_first", obs_q[0].win, pack9(lit));

    // Random in/out gaps over three frames.
    obs_q.delete(); fd_count = 0; rnd = 1;
    frame(0, 1, 0);
    frame(50, 1, 0);
    frame(100, 1, 0);
    rnd = 0;
    drain();
    check_i("rnd_count", obs_q.size(), 27);
    check_i("rnd_fdone", fd_count, 3);
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 9; i++)
        check_w("rnd_win", obs_q[f*9+i].win,
                pix_win(i / 3, i % 3, f * 50));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end
endmodule
